// File: rtl/mdio_frame_master_if.sv
// Command/response bundle between the PHY-configuration FSM (master) and
// mdio_frame_master (slave).
`timescale 1ns/1ps
interface mdio_frame_master_if;
    logic        i_new_cmd;
    logic [31:0] i_cmd;
    logic        o_rdy;
    logic        o_data_written_flag;
    logic        o_data_read_flag;
    logic [15:0] o_r_register_data;

    modport master (
        output i_new_cmd, i_cmd,
        input  o_rdy, o_data_written_flag, o_data_read_flag, o_r_register_data
    );

    modport slave (
        input  i_new_cmd, i_cmd,
        output o_rdy, o_data_written_flag, o_data_read_flag, o_r_register_data
    );
endinterface

// File: rtl/mdio_frame_master.sv
// Clause-22 MDIO master: shifts a packed 32-bit command word onto io_mdio LSB first.
// Optional preamble of PREAMBLE_LEN ones is compiled in with `define MDIO_PREAMBLE_EN.
`timescale 1ns/1ps
module mdio_frame_master #(
    parameter int PREAMBLE_LEN = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    mdio_frame_master_if.slave bus,
    inout  wire                io_mdio
);
    // One counter serves both the preamble and the 32 frame bit periods.
    localparam int CNT_W = $clog2(PREAMBLE_LEN + 33) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] FIRST_TA   = CNT_W'(14);
    localparam logic [CNT_W-1:0] FIRST_DATA = CNT_W'(16);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(31);
`ifdef MDIO_PREAMBLE_EN
    localparam logic [CNT_W-1:0] LAST_PRE   = CNT_W'(PREAMBLE_LEN - 1);
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        FRAME    = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      cmd_sh;
    logic [14:0]      rd_sh;
    logic             is_read;
    logic [15:0]      r_data;
    logic             load;
    logic             drive_en;
    logic             drive_bit;
    logic             rdy;
    logic             wr_flag;
    logic             rd_flag;
    logic             mdio_in;

    assign mdio_in = io_mdio;
    assign io_mdio = drive_en ? drive_bit : 1'bz;

    assign bus.o_rdy               = rdy;
    assign bus.o_data_written_flag = wr_flag;
    assign bus.o_data_read_flag    = rd_flag;
    assign bus.o_r_register_data   = r_data;

    always_comb begin
        state_n   = state;
        load      = 1'b0;
        drive_en  = 1'b0;
        drive_bit = 1'b1;
        rdy       = 1'b0;
        wr_flag   = 1'b0;
        rd_flag   = 1'b0;
        case (state)
            IDLE: begin
                rdy = 1'b1;
                if (bus.i_new_cmd) begin
                    load = 1'b1;
`ifdef MDIO_PREAMBLE_EN
                    state_n = PREAMBLE;
`else
                    state_n = FRAME;
`endif
                end
            end
`ifdef MDIO_PREAMBLE_EN
            PREAMBLE: begin
                drive_en  = 1'b1;
                drive_bit = 1'b1;
                if (cnt == LAST_PRE) begin
                    state_n = FRAME;
                end
            end
`endif
            FRAME: begin
                // Reads hand the line to the PHY from the turnaround onwards.
                drive_en  = !is_read || (cnt < FIRST_TA);
                drive_bit = cmd_sh[0];
                if (cnt == LAST_BIT) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                wr_flag = !is_read;
                rd_flag = is_read;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state   <= IDLE;
            cnt     <= '0;
            is_read <= 1'b0;
            r_data  <= '0;
        end else begin
            state <= state_n;
            if (state_n != state || state == IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
            if (load) begin
                is_read <= bus.i_cmd[2] & ~bus.i_cmd[3];
            end
            // Final data bit is sampled on the edge that ends the frame.
            if (state == FRAME && cnt == LAST_BIT && is_read) begin
                r_data <= {mdio_in, rd_sh};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (load) begin
            cmd_sh <= bus.i_cmd;
        end else if (state == FRAME) begin
            cmd_sh <= {1'b0, cmd_sh[31:1]};
        end
        if (state == FRAME && cnt >= FIRST_DATA && cnt != LAST_BIT) begin
            rd_sh <= {mdio_in, rd_sh[14:1]};
        end
    end
endmodule

// File: tb/tb_mdio_frame_master.sv
// Directed bench for mdio_frame_master with a bit-level PHY emulator on io_mdio.
`timescale 1ns/1ps
module tb_mdio_frame_master;
`ifdef MDIO_PREAMBLE_EN
    localparam int PRE = 32;
`else
    localparam int PRE = 0;
`endif
    localparam int DONE_CYC = PRE + 33;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wire  mdio;
    logic phy_oe = 1'b0;
    logic phy_bit = 1'b0;
    assign mdio = phy_oe ? phy_bit : 1'bz;

    mdio_frame_master_if bus();

    mdio_frame_master #(.PREAMBLE_LEN(32)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus),
        .io_mdio (mdio)
    );

    int total = 0;
    int bad = 0;
    int wcnt = 0;
    int rcnt = 0;
    int both = 0;
    logic [15:0] exp_rd = 16'h0000;
    logic [15:0] phy_mem [32];
    logic [31:0] wire_cap;

    always @(negedge clk) begin
        if (bus.o_data_written_flag === 1'b1) wcnt++;
        if (bus.o_data_read_flag === 1'b1) rcnt++;
        if (bus.o_data_written_flag === 1'b1 && bus.o_data_read_flag === 1'b1) both++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] wcmd(input int r, input logic [15:0] d);
        logic [4:0] ra;
        ra = 5'(r);
        return {d, 2'b01, ra, 5'd0, 2'b10, 2'b10};
    endfunction

    function automatic logic [31:0] rcmd(input int r);
        logic [4:0] ra;
        ra = 5'(r);
        return {16'h0000, 2'b01, ra, 5'd0, 2'b01, 2'b10};
    endfunction

    function automatic logic [15:0] wval(input int r);
        case (r)
            2:       return 16'h0141;
            27:      return 16'h848B;
            31:      return 16'h0000;
            default: return 16'(r * 16'h1357) ^ 16'hC3A5;
        endcase
    endfunction

    // Issue one command and follow it bit by bit until the cycle after its flag.
    task automatic run_frame(input logic [31:0] cmd, input logic [15:0] phy_data,
                             input logic hold_busy, input logic [31:0] junk);
        logic rd;
        int   k;
        int   waited;
        rd = cmd[2] & ~cmd[3];
        waited = 0;
        while (bus.o_rdy !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (bus.o_rdy !== 1'b1) begin
            bad++;
            $display("FAIL rdy_timeout: o_rdy=%b required 1", bus.o_rdy);
            return;
        end
        bus.i_cmd = cmd;
        bus.i_new_cmd = 1'b1;
        wire_cap = '0;
        for (int c = 1; c <= DONE_CYC; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (hold_busy) bus.i_cmd = junk;
                else bus.i_new_cmd = 1'b0;
            end
            if (c == DONE_CYC) bus.i_new_cmd = 1'b0;
            k = c - PRE - 1;
            phy_oe = 1'b0;
            if (c > PRE && c < DONE_CYC && rd && k >= 14) begin
                phy_oe = 1'b1;
                phy_bit = (k >= 16) ? phy_data[k-16] : 1'b0;
            end
            if (c == DONE_CYC) begin
                phy_oe = 1'b1;
                phy_bit = 1'b0;
            end
            #1;
            total++;
            if (c <= PRE) begin
                if (mdio !== 1'b1) begin
                    bad++;
                    $display("FAIL preamble c=%0d: line=%b required 1", c, mdio);
                end
            end else if (c < DONE_CYC) begin
                if (rd && k >= 14) begin
                    if (mdio !== phy_bit) begin
                        bad++;
                        $display("FAIL read_release k=%0d: line=%b required %b", k, mdio, phy_bit);
                    end
                end else begin
                    wire_cap[k] = (mdio === 1'b1);
                    if ((mdio === 1'b1) !== cmd[k]) begin
                        bad++;
                        $display("FAIL frame_bit k=%0d: line=%b required %b", k, mdio, cmd[k]);
                    end
                end
            end else begin
                if (mdio !== 1'b0) begin
                    bad++;
                    $display("FAIL done_release: line=%b required released", mdio);
                end
            end
            total++;
            if (c < DONE_CYC) begin
                if (bus.o_rdy !== 1'b0 || bus.o_data_written_flag !== 1'b0 ||
                    bus.o_data_read_flag !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_status c=%0d: rdy/wf/rf=%b%b%b required 000", c,
                             bus.o_rdy, bus.o_data_written_flag, bus.o_data_read_flag);
                end
            end else begin
                if (bus.o_rdy !== 1'b0 || bus.o_data_written_flag !== ~rd ||
                    bus.o_data_read_flag !== rd) begin
                    bad++;
                    $display("FAIL done_flags: rdy/wf/rf=%b%b%b required 0%b%b",
                             bus.o_rdy, bus.o_data_written_flag, bus.o_data_read_flag, ~rd, rd);
                end
                if (rd) exp_rd = phy_data;
            end
            total++;
            if (bus.o_r_register_data !== exp_rd) begin
                bad++;
                $display("FAIL rdata c=%0d: got %h required %h", c, bus.o_r_register_data, exp_rd);
            end
        end
        @(negedge clk);
        phy_oe = 1'b1;
        phy_bit = 1'b0;
        #1;
        total++;
        if (bus.o_rdy !== 1'b1 || bus.o_data_written_flag !== 1'b0 ||
            bus.o_data_read_flag !== 1'b0 || mdio !== 1'b0) begin
            bad++;
            $display("FAIL idle_after: rdy/wf/rf/line=%b%b%b%b required 1000",
                     bus.o_rdy, bus.o_data_written_flag, bus.o_data_read_flag, mdio);
        end
        phy_oe = 1'b0;
        if (!rd) phy_mem[wire_cap[13:9]] = wire_cap[31:16];
    endtask

    task automatic test_reset();
        bus.i_new_cmd = 1'b0;
        bus.i_cmd = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        phy_oe = 1'b1;
        phy_bit = 1'b0;
        #1;
        total++;
        if (bus.o_rdy !== 1'b1 || bus.o_data_written_flag !== 1'b0 ||
            bus.o_data_read_flag !== 1'b0 || mdio !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: rdy/wf/rf/line=%b%b%b%b required 1000",
                     bus.o_rdy, bus.o_data_written_flag, bus.o_data_read_flag, mdio);
        end
        total++;
        if (bus.o_r_register_data !== 16'h0000) begin
            bad++;
            $display("FAIL reset_rdata: got %h required 0000", bus.o_r_register_data);
        end
        phy_oe = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_reg0();
        int w0;
        int r0;
        w0 = wcnt;
        r0 = rcnt;
        run_frame(32'h1140_400A, 16'h0000, 1'b0, 32'h0);
        total++;
        if (wcnt - w0 != 1 || rcnt != r0) begin
            bad++;
            $display("FAIL write_reg0_flags: writes=%0d reads=%0d required 1 0", wcnt - w0, rcnt - r0);
        end
        total++;
        if (phy_mem[0] !== 16'h1140) begin
            bad++;
            $display("FAIL write_reg0_data: phy got %h required 1140", phy_mem[0]);
        end
    endtask

    task automatic test_read_reg1();
        int r0;
        r0 = rcnt;
        run_frame(32'h0000_4206, 16'h7949, 1'b0, 32'h0);
        total++;
        if (bus.o_r_register_data !== 16'h7949 || rcnt - r0 != 1) begin
            bad++;
            $display("FAIL read_reg1: data=%h reads=%0d required 7949 1",
                     bus.o_r_register_data, rcnt - r0);
        end
    endtask

    task automatic test_reset_mid();
        bus.i_cmd = 32'h1140_400A;
        bus.i_new_cmd = 1'b1;
        @(negedge clk);
        bus.i_new_cmd = 1'b0;
        repeat (PRE + 14) @(negedge clk);
        #1;
        total++;
        if (mdio !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_pre: line=%b required 1 (bit 14)", mdio);
        end
        rst_n = 1'b0;
        phy_oe = 1'b1;
        phy_bit = 1'b0;
        #1;
        total++;
        if (mdio !== 1'b0 || bus.o_rdy !== 1'b1 || bus.o_data_written_flag !== 1'b0 ||
            bus.o_data_read_flag !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_ctrl: line/rdy/wf/rf=%b%b%b%b required 0100",
                     mdio, bus.o_rdy, bus.o_data_written_flag, bus.o_data_read_flag);
        end
        total++;
        if (bus.o_r_register_data !== 16'h0000) begin
            bad++;
            $display("FAIL reset_mid_rdata: got %h required 0000", bus.o_r_register_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        phy_oe = 1'b0;
        exp_rd = 16'h0000;
        @(negedge clk);
        run_frame(32'h1140_400A, 16'h0000, 1'b0, 32'h0);
    endtask

    task automatic test_ignored_strobe();
        run_frame(wcmd(5, 16'hBEEF), 16'h0000, 1'b1, 32'hA5A5_7E06);
        total++;
        if (phy_mem[5] !== 16'hBEEF) begin
            bad++;
            $display("FAIL ignored_strobe: phy reg5=%h required BEEF", phy_mem[5]);
        end
    endtask

    task automatic test_back_to_back();
        int w0;
        int r0;
        w0 = wcnt;
        r0 = rcnt;
        for (int r = 0; r < 32; r++) run_frame(wcmd(r, wval(r)), 16'h0000, 1'b0, 32'h0);
        for (int r = 0; r < 32; r++) begin
            run_frame(rcmd(r), phy_mem[r], 1'b0, 32'h0);
            total++;
            if (bus.o_r_register_data !== wval(r)) begin
                bad++;
                $display("FAIL sweep_read reg=%0d: got %h required %h", r,
                         bus.o_r_register_data, wval(r));
            end
        end
        total++;
        if (wcnt - w0 != 32 || rcnt - r0 != 32) begin
            bad++;
            $display("FAIL sweep_flags: writes=%0d reads=%0d required 32 32", wcnt - w0, rcnt - r0);
        end
        total++;
        if (both != 0) begin
            bad++;
            $display("FAIL flag_exclusive: both-high cycles=%0d required 0", both);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) phy_mem[i] = 16'h0000;
        test_reset();
        test_write_reg0();
        test_read_reg1();
        test_reset_mid();
        test_ignored_strobe();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mdio_frame_master.md
Name: mdio_frame_master

Overview:
- Clause-22-style MDIO management master that serialises one 32-bit command word onto a bidirectional MDIO line. The MDC clock is i_clk, routed externally to the PHY.
- Sits between the PHY-configuration FSM, which packs register writes and reads for a Marvell PHY, and the PHY's MDIO pin.
- Executes write frames and read frames. Returns read data and one-cycle completion flags.

Parameters:
- PREAMBLE_LEN, 32, number of preamble '1' bits sent before each frame when the preamble is compiled in.

Ports:
- i_clk  in  1  system clock; one MDIO bit per cycle; also serves as MDC.
- i_reset  in  1  asynchronous, active-low reset.
- i_new_cmd  in  1  command strobe; accepted only while o_rdy=1.
- i_cmd  in  32  command word:
  - [1:0] ST, 2'b10 (wire order 0,1)
  - [3:2] OP, 2'b10 = write (wire 01), 2'b01 = read (wire 10)
  - [8:4] PHYAD
  - [13:9] REGAD
  - [15:14] TA, 2'b01 (wire 1,0)
  - [31:16] write data
- o_rdy  out  1  idle and able to accept a command.
- o_data_written_flag  out  1  one-cycle pulse when a write frame completes.
- o_data_read_flag  out  1  one-cycle pulse when a read frame completes; o_r_register_data is valid in the same cycle.
- o_r_register_data  out  16  last read data.
- io_mdio  inout  1  MDIO line; high-Z when not driving (external pull-up).

Behaviour:
- Reset (i_reset=0, asynchronous):
  - o_rdy=1, both flags=0, o_r_register_data=0, io_mdio=Z, state=IDLE.
  - Any frame in progress is aborted immediately and the line is released.
- State machine: IDLE -> PREAMBLE -> FRAME -> DONE -> IDLE. All registers update on the rising edge of i_clk.
- IDLE:
  - io_mdio=Z, o_rdy=1.
  - On a rising edge with i_new_cmd=1: latch i_cmd into a shift register, drop o_rdy, go to PREAMBLE.
  - i_new_cmd while o_rdy=0 is ignored (no queueing).
- Read/write decode, from the latched command: i_cmd[2]=1 and i_cmd[3]=0 is a read; any other OP value is a write.
- PREAMBLE: drive '1' for PREAMBLE_LEN cycles.
- FRAME:
  - 32 bit periods, each one cycle long. Bit k is i_cmd[k], LSB first. There is no field reordering; the packer owns bit order.
  - Write: all 32 bits are driven.
  - Read: bits 0..13 are driven. io_mdio is released (Z) for bits 14..31.
  - Read sampling: each data bit (periods 16..31) is sampled at the rising edge that ends its period. The bit sampled in period 16+n goes into o_r_register_data[n].
  - o_r_register_data updates only when a read completes; it holds its value otherwise, including across writes.
- DONE (one cycle):
  - io_mdio=Z.
  - Pulse o_data_written_flag (write) or o_data_read_flag (read).
  - o_rdy returns to 1 on the following cycle.
- Latency: acceptance edge to flag = PREAMBLE_LEN+32+1 cycles (65 by default). The next command can be accepted one cycle after the flag.
- Both flags are never high simultaneously.
- The line is never driven while o_rdy=1.

Optional Feature:
- Macro MDIO_PREAMBLE_EN.
- Defined: the PREAMBLE state is present and sends PREAMBLE_LEN ones before every frame.
- Undefined: preamble suppression. IDLE goes directly to FRAME, latency is 33 cycles, and PREAMBLE_LEN is ignored.

Test Plan:
- Reset mid-operation:
  - Stimulus: assert i_reset=0 for 3 cycles during a write frame.
  - Required: io_mdio=Z immediately, o_rdy=1, flags=0, o_r_register_data=0; the next command executes normally.
- Write to register 0:
  - Stimulus: write 0x1140, PHYAD=0, i.e. i_cmd=0x1140_400A.
  - Required: with MDIO_PREAMBLE_EN, 32 ones, then the i_cmd bits LSB first on io_mdio; o_data_written_flag pulses exactly 65 cycles after acceptance; no read flag.
- Read from register 1:
  - Stimulus: read REGAD=1, i_cmd=0x0000_4206; the PHY model drives 0x7949 LSB first in periods 16..31.
  - Required: line is Z from period 14; o_data_read_flag pulses with o_r_register_data=0x7949.
- Ignored strobe:
  - Stimulus: hold i_new_cmd=1 with a different i_cmd while busy.
  - Required: the in-flight frame is unchanged and no second frame starts until o_rdy=1.
- Full sweep:
  - Stimulus: back-to-back writes to all 32 registers with a PHY emulator, then 32 reads.
  - Required: every read returns the written value (e.g. reg 2=0x0141, reg 27=0x848B, reg 31=0x0000); 32 write flags and 32 read flags.
- Preamble suppressed:
  - Stimulus: build without MDIO_PREAMBLE_EN and repeat the register-0 write.
  - Required: frame begins the cycle after acceptance; flag pulses 33 cycles after acceptance.
